// File: rtl/lynx_bfm_pkg.sv
// Shared definitions for NoC bench endpoints: throttle modes and flit field layout.
package lynx_bfm_pkg;

   typedef enum logic [1:0] {
      BP_ALWAYS   = 2'd0,
      BP_PERIODIC = 2'd1,
      BP_RANDOM   = 2'd2
   } bp_mode_e;

   // Flit layout, MSB first: src (a bits), dst (a bits), id (8 bits), seq (remaining bits).
   function automatic int seq_w(input int width, input int a);
      return width - 2 * a - 8;
   endfunction

   function automatic int id_pos(input int width, input int a);
      return seq_w(width, a) + 7;
   endfunction

   function automatic int dst_pos(input int width, input int a);
      return seq_w(width, a) + 8 + a - 1;
   endfunction

   function automatic int src_pos(input int width, input int a);
      return seq_w(width, a) + 8 + 2 * a - 1;
   endfunction

endpackage

// File: rtl/sink_throttle.sv
// Backpressure generator: always ready, periodic duty pattern or LFSR-driven random stalls.
module sink_throttle
   import lynx_bfm_pkg::*;
#(
   parameter int          BP_MODE   = 0,
   parameter int          BP_PERIOD = 4,
   parameter int          BP_ON     = 3,
   parameter logic [7:0]  BP_THRESH = 8'd64,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic clk,
   input  logic rst,
   output logic ready
);

   // Wide enough to hold BP_PERIOD itself, so BP_ON == BP_PERIOD is representable.
   localparam int              PW      = $clog2(BP_PERIOD + 1);
   localparam logic [PW-1:0]   LAST_C  = PW'(BP_PERIOD - 1);
   localparam logic [PW-1:0]   ON_C    = PW'(BP_ON);
   localparam bp_mode_e        MODE    = bp_mode_e'(BP_MODE[1:0]);

   logic [PW-1:0] period_q, period_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic          ready_q, ready_d;
   logic          feedback;

   // Next-state: period counter wraps, LFSR free-runs, ready chosen by mode.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
      period_d = (period_q == LAST_C) ? '0 : period_q + 1'b1;
      feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
      lfsr_d   = {lfsr_q[14:0], feedback};
      ready_d  = 1'b1;
      case (MODE)
         BP_ALWAYS:   ready_d = 1'b1;
         BP_PERIODIC: ready_d = (period_q < ON_C);
         BP_RANDOM:   ready_d = (lfsr_q[7:0] >= BP_THRESH);
         default:     ready_d = 1'b1;
      endcase
   end

   // State registers; ready stays low until the first edge after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         period_q <= '0;
         lfsr_q   <= LFSR_SEED;
         ready_q  <= 1'b0;
      end else begin
         period_q <= period_d;
         lfsr_q   <= lfsr_d;
         ready_q  <= ready_d;
      end
   end

   assign ready = ready_q;

endmodule

// File: rtl/sink_checker.sv
// NoC traffic sink: throttles input, checks per-source sequence and route, counts flits.
module sink_checker
   import lynx_bfm_pkg::*;
#(
   parameter int          WIDTH        = 32,
   parameter int          N            = 16,
   parameter int          N_ADDR_WIDTH = $clog2(N),
   parameter logic [7:0]  ID           = 8'd0,
   parameter int          NODE         = 15,
   parameter int          NUM_TESTS    = 1000,
   parameter int          BP_MODE      = 0,
   parameter int          BP_PERIOD    = 4,
   parameter int          BP_ON        = 3,
   parameter logic [7:0]  BP_THRESH    = 8'd64,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter int          CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] rx_count,
   output logic [15:0]      err_count
);

   localparam int A       = N_ADDR_WIDTH;
   localparam int DW      = seq_w(WIDTH, A);
   localparam int SRC_POS = src_pos(WIDTH, A);
   localparam int DST_POS = dst_pos(WIDTH, A);
   localparam int ID_POS  = id_pos(WIDTH, A);

   localparam logic [A-1:0]     NODE_C      = A'(NODE);
   localparam logic [A:0]       N_C         = (A + 1)'(N);
   localparam logic [CNT_W-1:0] NUM_TESTS_C = CNT_W'(NUM_TESTS);

   // Field decode
   logic [A-1:0]  src;
   logic [A-1:0]  dst;
   logic [7:0]    flit_id;
   logic [DW-1:0] seq;

   assign src     = data_in[SRC_POS -: A];
   assign dst     = data_in[DST_POS -: A];
   assign flit_id = data_in[ID_POS -: 8];
   assign seq     = data_in[DW-1:0];

   // The id field and sink id exist for tracing only.
   logic unused_ok;
   assign unused_ok = ^{ID, flit_id};

   sink_throttle #(
      .BP_MODE   (BP_MODE),
      .BP_PERIOD (BP_PERIOD),
      .BP_ON     (BP_ON),
      .BP_THRESH (BP_THRESH),
      .LFSR_SEED (LFSR_SEED)
   ) u_throttle (
      .clk   (clk),
      .rst   (rst),
      .ready (ready_out)
   );

   logic accept;
   assign accept = valid_in && ready_out;

   // A power-of-two node count makes every src encoding legal.
   logic src_ok;
   generate
      if (N == (1 << A)) begin : g_src_full
         assign src_ok = 1'b1;
      end else begin : g_src_range
         assign src_ok = ({1'b0, src} < N_C);
      end
   endgenerate

   logic [DW-1:0]    expected_q [N];
   logic [DW-1:0]    expected_d [N];
   logic [CNT_W-1:0] rx_count_q, rx_count_d;
   logic [15:0]      err_count_q, err_count_d;
   logic             done_q, done_d;
   logic             error_q, error_d;

   logic [A-1:0] src_idx;
   logic         route_err;
   logic         seq_err;
   logic         flit_err;

   // Out-of-range sources never touch the table; they read entry 0 and the result is masked.
   assign src_idx   = src_ok ? src : '0;
   assign route_err = (dst != NODE_C) || !src_ok;
   assign seq_err   = src_ok && (seq != expected_q[src_idx]);
   assign flit_err  = route_err || seq_err;

   // Per-flit check and bookkeeping, applied only on an accepting edge.
   always_comb begin
      expected_d  = expected_q;
      rx_count_d  = rx_count_q;
      err_count_d = err_count_q;
      done_d      = done_q;
      error_d     = error_q;
      if (accept) begin
         // Always resync to the received seq so a single gap reports one error.
         if (src_ok) begin
            expected_d[src_idx] = seq + 1'b1;
         end
         if (rx_count_q != '1) begin
            rx_count_d = rx_count_q + 1'b1;
         end
         if (flit_err) begin
            error_d = 1'b1;
            if (err_count_q != '1) begin
               err_count_d = err_count_q + 1'b1;
            end
         end
         if (rx_count_d >= NUM_TESTS_C) begin
            done_d = 1'b1;
         end
      end
   end

   // Checker state: expected-seq table, counters and sticky flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the expected-seq table is reset because a fresh run must start every source at seq 0.
         for (int i = 0; i < N; i++) begin
            expected_q[i] <= '0;
         end
         rx_count_q  <= '0;
         err_count_q <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         expected_q  <= expected_d;
         rx_count_q  <= rx_count_d;
         err_count_q <= err_count_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign rx_count  = rx_count_q;
   assign err_count = err_count_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_sink_checker.sv
// Scoreboard bench for sink_checker: randomized flits against a behavioural model.
module tb_sink_checker;

   localparam int WIDTH     = 32;
   localparam int N         = 12;
   localparam int A         = $clog2(N);
   localparam int DW        = WIDTH - 2 * A - 8;
   localparam int NODE      = 15;
   localparam int NUM_TESTS = 5;

   typedef struct {
      int rx;
      int errc;
      bit err;
      bit done;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [WIDTH-1:0] data_in = '0;
   logic             valid_in = 1'b0;
   logic             ready_out, done, error;
   logic [31:0]      rx_count;
   logic [15:0]      err_count;

   logic        a_ready, a_done, a_error, z_ready, z_done, z_error, r_ready, r_done, r_error;
   logic [31:0] a_rx, z_rx, r_rx;
   logic [15:0] a_err, z_err, r_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sink_checker #(.WIDTH(WIDTH), .N(N), .NODE(NODE), .NUM_TESTS(NUM_TESTS),
                  .BP_MODE(1), .BP_PERIOD(4), .BP_ON(3)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
      .done(done), .error(error), .rx_count(rx_count), .err_count(err_count));

   sink_checker #(.BP_MODE(0)) dut_always (
      .clk(clk), .rst(rst), .data_in(32'h0), .valid_in(1'b0), .ready_out(a_ready),
      .done(a_done), .error(a_error), .rx_count(a_rx), .err_count(a_err));

   sink_checker #(.BP_MODE(2), .BP_THRESH(8'd0)) dut_rand0 (
      .clk(clk), .rst(rst), .data_in(32'h0), .valid_in(1'b0), .ready_out(z_ready),
      .done(z_done), .error(z_error), .rx_count(z_rx), .err_count(z_err));

   sink_checker #(.BP_MODE(2), .BP_THRESH(8'd128)) dut_rand128 (
      .clk(clk), .rst(rst), .data_in(32'h0), .valid_in(1'b0), .ready_out(r_ready),
      .done(r_done), .error(r_error), .rx_count(r_rx), .err_count(r_err));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int   exp_seq [N];
   exp_t model;
   exp_t sb [$];
   exp_t last;
   bit   mon_en = 1'b0;

   function automatic void model_reset();
      foreach (exp_seq[i]) exp_seq[i] = 0;
      model = '{rx: 0, errc: 0, err: 1'b0, done: 1'b0};
   endfunction

   function automatic exp_t model_accept(input int s, input int d, input int q);
      bit route_bad = (d != NODE) || (s >= N);
      bit seq_bad   = (s < N) && (q != exp_seq[s]);
      if (s < N) exp_seq[s] = (q + 1) % (1 << DW);
      model.rx++;
      if (route_bad || seq_bad) begin
         model.errc++;
         model.err = 1'b1;
      end
      if (model.rx >= NUM_TESTS) model.done = 1'b1;
      return model;
   endfunction

   function automatic logic [WIDTH-1:0] mk(input int s, input int d, input int q);
      return {s[A-1:0], d[A-1:0], 8'hA5, q[DW-1:0]};
   endfunction

   // Cycles since reset release (1 after the first edge out of reset).
   int cyc;
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // Ready statistics for the stand-alone throttle instances.
   int aux_n = 0, a_low = 0, z_low = 0, r_high = 0;
   always @(negedge clk) begin
      if (!rst && cyc >= 1) begin
         aux_n <= aux_n + 1;
         if (!a_ready) a_low <= a_low + 1;
         if (!z_ready) z_low <= z_low + 1;
         if (r_ready)  r_high <= r_high + 1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         valid_in = 1'b0;
         data_in  = $urandom;
      end
   endtask

   task automatic send(input int s, input int d, input int q);
      int waited = 0;
      bit acc = 1'b0;
      while (!acc) begin
         @(negedge clk);
         data_in  = mk(s, d, q);
         valid_in = 1'b1;
         if (ready_out) begin
            acc = 1'b1;
            sb.push_back(model_accept(s, d, q));
         end else if (++waited > 16) begin
            check("send_timeout", 0, 1);
            break;
         end
      end
   endtask

   // Valid held for ncyc cycles from one source; also checks the 3-of-4 ready pattern.
   task automatic stream(input int s, input int ncyc, output int nacc);
      nacc = 0;
      repeat (ncyc) begin
         @(negedge clk);
         data_in  = mk(s, NODE, exp_seq[s]);
         valid_in = 1'b1;
         check("ready_pattern", ready_out, ((cyc - 1) % 4) < 3);
         if (ready_out) begin
            nacc++;
            sb.push_back(model_accept(s, NODE, exp_seq[s]));
         end
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      bit pend;
      last = '{rx: 0, errc: 0, err: 1'b0, done: 1'b0};
      forever begin
         @(negedge clk);
         #2;
         pend = mon_en && valid_in && ready_out && !rst;
         @(posedge clk);
         #1;
         if (!mon_en) continue;
         if (pend) begin
            if (sb.size() == 0) check("sb_underflow", 0, 1);
            else last = sb.pop_front();
         end
         check("rx_count", rx_count, last.rx);
         check("err_count", err_count, last.errc);
         check("error", error, last.err);
         check("done", done, last.done);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int n;
      int guard;
      int s, d, q;
      model_reset();
      #1 rst = 1'b1;
      #2;
      check("rst_ready", ready_out, 0);
      check("rst_rx", rx_count, 0);
      check("rst_done", done, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;

      // Periodic throttle: 12 cycles with valid held accept 9 flits.
      stream(3, 12, n);
      check("stream_accepts", n, 9);
      idle(2);
      check("done_sticky", done, 1);

      // Sequence gap from src 2 reports exactly one error, then resyncs.
      send(2, NODE, 0); send(2, NODE, 1); send(2, NODE, 3); send(2, NODE, 4);
      idle(2);
      check("gap_err_count", err_count, 1);
      check("gap_error", error, 1);

      // Wrong destination, then wrong destination plus wrong seq (counted once).
      send(4, 7, 0);
      send(4, 7, 5);
      idle(2);
      check("route_err_count", err_count, 3);

      // Source out of range leaves the expected table alone.
      send(12, NODE, 0);
      send(0, NODE, 0);
      idle(2);
      check("src_range_err", err_count, 4);

      // Seq wrap from all-ones to zero is legal.
      send(5, NODE, (1 << DW) - 1);
      send(5, NODE, 0);
      send(5, NODE, 1);
      idle(2);
      check("wrap_err_count", err_count, 5);

      // Randomized traffic.
      repeat (200) begin
         s = $urandom_range(0, 13);
         d = ($urandom_range(0, 7) == 0) ? 7 : NODE;
         if (s < N && $urandom_range(0, 7) != 0) q = exp_seq[s];
         else q = $urandom_range(0, (1 << DW) - 1);
         send(s, d, q);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
      idle(2);
      check("sb_drained", sb.size(), 0);

      // Asynchronous reset mid-stream.
      @(negedge clk);
      data_in  = mk(3, NODE, exp_seq[3]);
      valid_in = 1'b1;
      #2;
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      check("arst_ready", ready_out, 0);
      check("arst_done", done, 0);
      check("arst_error", error, 0);
      check("arst_rx", rx_count, 0);
      check("arst_err_count", err_count, 0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("post_rel_ready", ready_out, 0);
      model_reset();
      sb.delete();
      last = '{rx: 0, errc: 0, err: 1'b0, done: 1'b0};
      @(posedge clk);
      #1;
      check("first_edge_ready", ready_out, 1);
      check("inflight_not_counted", rx_count, 0);
      @(negedge clk);
      valid_in = 1'b0;
      mon_en = 1'b1;

      // Table cleared by reset: src 3 restarts at seq 0 cleanly.
      stream(3, 8, n);
      check("post_rst_accepts", n, 6);
      idle(2);
      check("post_rst_err", err_count, 0);

      // Let the throttle instances accumulate statistics.
      guard = 0;
      while (aux_n < 10000 && guard < 12000) begin
         idle(1);
         guard++;
      end
      check("aux_samples", aux_n >= 10000, 1);
      check("mode0_always_ready", a_low, 0);
      check("thresh0_always_ready", z_low, 0);
      check("thresh128_duty", (r_high * 100 >= aux_n * 40) && (r_high * 100 <= aux_n * 60), 1);
      check("idle_dut_rx", a_rx | z_rx | r_rx, 0);
      check("idle_dut_err", {a_error, z_error, r_error, a_done, z_done, r_done}, 0);
      check("idle_dut_errc", a_err | z_err | r_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
